// File: rtl/ibus_pkg.sv
// Shared instruction-bus types and widths for the fetch responder and the CPU bench.
package ibus_pkg;

    localparam int IBUS_ADDR_W = 64;
    localparam int IBUS_DATA_W = 64;
    localparam int IBUS_ID_W   = 16;

    typedef struct packed {
        logic [IBUS_ADDR_W-1:0] address;
        logic [IBUS_ID_W-1:0]   id;
    } ibus_cmd_t;

    typedef struct packed {
        logic [IBUS_DATA_W-1:0] data;
        logic [IBUS_ADDR_W-1:0] address;
        logic [IBUS_ID_W-1:0]   id;
    } ibus_rsp_t;

endpackage

// File: rtl/ibus_rsp_fifo.sv
// Response queue: synchronous FIFO of ibus_rsp_t with clear, full/empty and occupancy.
module ibus_rsp_fifo
    import ibus_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  ibus_rsp_t        din,
    output ibus_rsp_t        dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    ibus_rsp_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/ibus_mem_responder.sv
// Memory end of the io_iBus fetch interface: fixed-latency reads from an internal
// word array, in-order responses, bounded outstanding fetches, stall and flush.
module ibus_mem_responder
    import ibus_pkg::*;
#(
    parameter int    ADDR_W    = IBUS_ADDR_W,
    parameter int    DATA_W    = IBUS_DATA_W,
    parameter int    ID_W      = IBUS_ID_W,
    parameter int    LATENCY   = 2,
    parameter int    DEPTH     = 4,
    parameter int    MEM_WORDS = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic              io_clk,
    input  logic              io_reset,
    input  logic              io_cmd_valid,
    output logic              io_cmd_ready,
    input  logic [ADDR_W-1:0] io_cmd_payload_address,
    input  logic [ID_W-1:0]   io_cmd_payload_id,
    output logic              io_rsp_valid,
    output logic [DATA_W-1:0] io_rsp_payload_data,
    output logic [ADDR_W-1:0] io_rsp_payload_address,
    output logic [ID_W-1:0]   io_rsp_payload_id,
    input  logic              io_stall,
    input  logic              io_flush,
    input  logic              io_load_valid,
    input  logic [ADDR_W-1:0] io_load_address,
    input  logic [DATA_W-1:0] io_load_data
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [CNT_W-1:0] count;
    logic             fire;
    logic             emit;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] ld_idx;
    ibus_cmd_t        cmd;

    logic             vld_p [1:LATENCY];
    ibus_rsp_t        rsp_p [1:LATENCY];

    ibus_rsp_t        head;
    ibus_rsp_t        fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             unused_bits;

    assign io_cmd_ready = !io_reset && (count < CNT_W'(DEPTH));
    assign fire         = io_cmd_valid && io_cmd_ready;
    assign cmd          = '{address: io_cmd_payload_address, id: io_cmd_payload_id};

    // Upper address bits alias the array; low three bits select a byte and are only echoed.
    assign rd_idx = io_cmd_payload_address[IDX_W+2:3];
    assign ld_idx = io_load_address[IDX_W+2:3];

    always_ff @(posedge io_clk) begin
        if (io_load_valid) mem[ld_idx] <= io_load_data;
    end

    // Stage 1: registered read (read-first against a same-cycle load); later stages shift.
    always_ff @(posedge io_clk) begin
        rsp_p[1] <= '{data: mem[rd_idx], address: cmd.address, id: cmd.id};
        for (int k = 2; k <= LATENCY; k++) rsp_p[k] <= rsp_p[k-1];
    end

    always_ff @(posedge io_clk or posedge io_reset) begin
        if (io_reset) begin
            for (int k = 1; k <= LATENCY; k++) vld_p[k] <= 1'b0;
            count <= '0;
        end else begin
            vld_p[1] <= fire;
            for (int k = 2; k <= LATENCY; k++) vld_p[k] <= vld_p[k-1] && !io_flush;
            if (io_flush) count <= CNT_W'(fire);
            else          count <= count + CNT_W'(fire) - CNT_W'(emit);
        end
    end

    // Final stage bypasses the queue when it is empty, giving command-to-response = LATENCY.
    always_comb begin
        head = fifo_empty ? rsp_p[LATENCY] : fifo_dout;
        emit = !io_stall && !io_flush && (!fifo_empty || vld_p[LATENCY]);
        pop  = emit && !fifo_empty;
        push = vld_p[LATENCY] && !io_flush && !(emit && fifo_empty);
    end

    ibus_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk   (io_clk),
        .rst   (io_reset),
        .push  (push),
        .pop   (pop),
        .clear (io_flush),
        .din   (rsp_p[LATENCY]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign io_rsp_valid           = emit;
    assign io_rsp_payload_data    = emit ? head.data    : '0;
    assign io_rsp_payload_address = emit ? head.address : '0;
    assign io_rsp_payload_id      = emit ? head.id      : '0;

    assign unused_bits = ^{io_load_address[ADDR_W-1:IDX_W+3], io_load_address[2:0],
                           fifo_full, fifo_level};

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Bench for ibus_mem_responder: directed vector table, hand sequences, and random traffic
// checked against a queue-based reference model.
module tb_ibus_mem_responder;

    localparam int LAT = 2;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        io_reset = 1'b1;
    logic        io_cmd_valid = 1'b0;
    logic        io_cmd_ready;
    logic [63:0] io_cmd_payload_address = '0;
    logic [15:0] io_cmd_payload_id = '0;
    logic        io_rsp_valid;
    logic [63:0] io_rsp_payload_data;
    logic [63:0] io_rsp_payload_address;
    logic [15:0] io_rsp_payload_id;
    logic        io_stall = 1'b0;
    logic        io_flush = 1'b0;
    logic        io_load_valid = 1'b0;
    logic [63:0] io_load_address = '0;
    logic [63:0] io_load_data = '0;

    ibus_mem_responder #(
        .LATENCY (LAT),
        .DEPTH   (DEP)
    ) dut (
        .io_clk                 (clk),
        .io_reset               (io_reset),
        .io_cmd_valid           (io_cmd_valid),
        .io_cmd_ready           (io_cmd_ready),
        .io_cmd_payload_address (io_cmd_payload_address),
        .io_cmd_payload_id      (io_cmd_payload_id),
        .io_rsp_valid           (io_rsp_valid),
        .io_rsp_payload_data    (io_rsp_payload_data),
        .io_rsp_payload_address (io_rsp_payload_address),
        .io_rsp_payload_id      (io_rsp_payload_id),
        .io_stall               (io_stall),
        .io_flush               (io_flush),
        .io_load_valid          (io_load_valid),
        .io_load_address        (io_load_address),
        .io_load_data           (io_load_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: outstanding fetches in command order, each releasable from its due cycle.
    typedef struct {
        int          due;
        logic [63:0] data;
        logic [63:0] addr;
        logic [15:0] id;
    } ent_t;

    ent_t        q[$];
    logic [63:0] mem_m [1024];
    int          cyc = 0;

    logic        act_ready, act_valid;
    logic [63:0] act_data, act_addr;
    logic [15:0] act_id;

    task automatic step(input bit cmp);
        bit   exp_ready, exp_emit;
        ent_t e;
        @(negedge clk);
        act_ready = io_cmd_ready;
        act_valid = io_rsp_valid;
        act_data  = io_rsp_payload_data;
        act_addr  = io_rsp_payload_address;
        act_id    = io_rsp_payload_id;
        exp_ready = !io_reset && (q.size() < DEP);
        exp_emit  = !io_reset && !io_stall && !io_flush && (q.size() > 0) && (q[0].due <= cyc);
        if (cmp) begin
            check($sformatf("m_ready@%0d", cyc), act_ready, exp_ready);
            check($sformatf("m_rsp_valid@%0d", cyc), act_valid, exp_emit);
            if (exp_emit) begin
                check($sformatf("m_rsp_data@%0d", cyc), act_data, q[0].data);
                check($sformatf("m_rsp_addr@%0d", cyc), act_addr, q[0].addr);
                check($sformatf("m_rsp_id@%0d", cyc), act_id, q[0].id);
            end
            if (io_reset) begin
                check($sformatf("m_rst_data@%0d", cyc), act_data, 64'h0);
                check($sformatf("m_rst_addr@%0d", cyc), act_addr, 64'h0);
                check($sformatf("m_rst_id@%0d", cyc), act_id, 64'h0);
            end
        end
        if (io_reset) begin
            q.delete();
        end else begin
            if (io_flush) q.delete();
            else if (exp_emit) void'(q.pop_front());
            if (io_cmd_valid && exp_ready) begin
                e.due  = cyc + LAT;
                e.data = mem_m[io_cmd_payload_address[12:3]];
                e.addr = io_cmd_payload_address;
                e.id   = io_cmd_payload_id;
                q.push_back(e);
            end
        end
        if (io_load_valid) mem_m[io_load_address[12:3]] = io_load_data;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        io_cmd_valid = 1'b0;
        io_stall     = 1'b0;
        io_flush     = 1'b0;
        io_load_valid = 1'b0;
        for (int i = 0; i < n; i++) step(1);
    endtask

    typedef struct {
        bit          cv;
        logic [63:0] ca;
        logic [15:0] cid;
        bit          lv;
        logic [63:0] la;
        logic [63:0] ld;
        bit          er;
        bit          ev;
        logic [63:0] ed;
        logic [63:0] ea;
        logic [15:0] eid;
    } vec_t;

    function automatic vec_t mk(bit cv, logic [63:0] ca, logic [15:0] cid, bit lv,
                                logic [63:0] la, logic [63:0] ld, bit ev,
                                logic [63:0] ed, logic [63:0] ea, logic [15:0] eid);
        vec_t v;
        v.cv = cv; v.ca = ca; v.cid = cid;
        v.lv = lv; v.la = la; v.ld = ld;
        v.er = 1'b1; v.ev = ev; v.ed = ed; v.ea = ea; v.eid = eid;
        return v;
    endfunction

    localparam logic [63:0] W0   = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] W10  = 64'h0000_0013_0000_0093;
    localparam logic [63:0] NEWD = 64'h0123_4567_89AB_CDEF;

    vec_t tbl [19];
    int   accepts;

    initial begin
        tbl[0]  = mk(1, 64'h80,   5, 0, 0, 0,       0, 0, 0, 0);
        tbl[1]  = mk(0, 0,        0, 0, 0, 0,       0, 0, 0, 0);
        tbl[2]  = mk(0, 0,        0, 0, 0, 0,       1, W10, 64'h80, 5);
        tbl[3]  = mk(1, 64'h0,    1, 0, 0, 0,       0, 0, 0, 0);
        tbl[4]  = mk(1, 64'h8,    2, 0, 0, 0,       0, 0, 0, 0);
        tbl[5]  = mk(1, 64'h10,   3, 0, 0, 0,       1, W0,     64'h0,  1);
        tbl[6]  = mk(1, 64'h18,   4, 0, 0, 0,       1, W0 | 1, 64'h8,  2);
        tbl[7]  = mk(0, 0,        0, 0, 0, 0,       1, W0 | 2, 64'h10, 3);
        tbl[8]  = mk(0, 0,        0, 0, 0, 0,       1, W0 | 3, 64'h18, 4);
        tbl[9]  = mk(0, 0,        0, 0, 0, 0,       0, 0, 0, 0);
        tbl[10] = mk(1, 64'h8005, 7, 0, 0, 0,       0, 0, 0, 0);
        tbl[11] = mk(0, 0,        0, 0, 0, 0,       0, 0, 0, 0);
        tbl[12] = mk(0, 0,        0, 0, 0, 0,       1, W0, 64'h8005, 7);
        tbl[13] = mk(1, 64'h18,   8, 1, 64'h18, NEWD, 0, 0, 0, 0);
        tbl[14] = mk(0, 0,        0, 0, 0, 0,       0, 0, 0, 0);
        tbl[15] = mk(0, 0,        0, 0, 0, 0,       1, W0 | 3, 64'h18, 8);
        tbl[16] = mk(1, 64'h18,   9, 0, 0, 0,       0, 0, 0, 0);
        tbl[17] = mk(0, 0,        0, 0, 0, 0,       0, 0, 0, 0);
        tbl[18] = mk(0, 0,        0, 0, 0, 0,       1, NEWD, 64'h18, 9);

        // Reset state, then release
        #1;
        step(1);
        check("rst_ready", act_ready, 1'b0);
        check("rst_rsp_valid", act_valid, 1'b0);
        step(1);
        io_reset = 1'b0;
        step(1);
        check("ready_after_release", act_ready, 1'b1);

        // Preload every word so model and memory agree everywhere
        io_load_valid = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            io_load_address = 64'(i) << 3;
            io_load_data    = (i == 'h10) ? W10 : (W0 | 64'(i));
            step(0);
        end
        idle(2);

        for (int i = 0; i < 19; i++) begin
            io_cmd_valid           = tbl[i].cv;
            io_cmd_payload_address = tbl[i].ca;
            io_cmd_payload_id      = tbl[i].cid;
            io_load_valid          = tbl[i].lv;
            io_load_address        = tbl[i].la;
            io_load_data           = tbl[i].ld;
            step(0);
            check($sformatf("t%0d_ready", i), act_ready, tbl[i].er);
            check($sformatf("t%0d_rsp_valid", i), act_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                check($sformatf("t%0d_rsp_data", i), act_data, tbl[i].ed);
                check($sformatf("t%0d_rsp_addr", i), act_addr, tbl[i].ea);
                check($sformatf("t%0d_rsp_id", i), act_id, tbl[i].eid);
            end
        end
        idle(3);

        // Stall with command held: exactly DEPTH accepts, then drain in order
        accepts = 0;
        io_stall = 1'b1;
        io_cmd_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            io_cmd_payload_address = 64'h20 + 64'(k * 8);
            io_cmd_payload_id      = 16'(40 + k);
            step(1);
            if (act_ready) accepts++;
            check($sformatf("stall_no_rsp_%0d", k), act_valid, 1'b0);
        end
        check("stall_accepts", 64'(accepts), 64'(DEP));
        io_stall = 1'b0;
        io_cmd_valid = 1'b0;
        step(1);
        check("post_stall_rsp0_valid", act_valid, 1'b1);
        check("post_stall_rsp0_id", act_id, 16'd40);
        check("ready_at_first_emit", act_ready, 1'b0);
        step(1);
        check("ready_after_first_emit", act_ready, 1'b1);
        check("post_stall_rsp1_id", act_id, 16'd41);
        step(1);
        check("post_stall_rsp2_id", act_id, 16'd42);
        step(1);
        check("post_stall_rsp3_id", act_id, 16'd43);
        step(1);
        check("post_stall_drained", act_valid, 1'b0);
        idle(2);

        // Flush with a redirected fetch in the same cycle
        io_stall = 1'b1;
        io_cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            io_cmd_payload_address = 64'(k * 8);
            io_cmd_payload_id      = 16'(20 + k);
            step(1);
        end
        io_stall = 1'b0;
        io_flush = 1'b1;
        io_cmd_payload_address = 64'h200;
        io_cmd_payload_id      = 16'd9;
        step(1);
        check("flush_cycle_no_rsp", act_valid, 1'b0);
        io_flush = 1'b0;
        io_cmd_valid = 1'b0;
        step(1);
        check("flush_p1_no_rsp", act_valid, 1'b0);
        step(1);
        check("flush_p2_rsp_valid", act_valid, 1'b1);
        check("flush_p2_rsp_id", act_id, 16'd9);
        check("flush_p2_rsp_addr", act_addr, 64'h200);
        check("flush_p2_rsp_data", act_data, W0 | 64'h40);
        for (int k = 0; k < 3; k++) begin
            step(1);
            check($sformatf("flush_tail_%0d", k), act_valid, 1'b0);
        end

        // Flush while stalled still empties the queue
        io_stall = 1'b1;
        io_cmd_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            io_cmd_payload_address = 64'(k * 8);
            io_cmd_payload_id      = 16'(50 + k);
            step(1);
        end
        io_cmd_valid = 1'b0;
        step(1);
        step(1);
        io_flush = 1'b1;
        step(1);
        io_flush = 1'b0;
        io_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check($sformatf("stall_flush_no_rsp_%0d", k), act_valid, 1'b0);
        end
        check("stall_flush_ready", act_ready, 1'b1);

        // Reset one cycle before a pending response
        io_cmd_valid = 1'b1;
        io_cmd_payload_address = 64'h8;
        io_cmd_payload_id      = 16'd30;
        step(1);
        io_cmd_valid = 1'b0;
        io_reset = 1'b1;
        step(1);
        check("midrst_ready", act_ready, 1'b0);
        check("midrst_rsp_valid", act_valid, 1'b0);
        check("midrst_rsp_id", act_id, 16'd0);
        step(1);
        check("midrst_rsp_valid2", act_valid, 1'b0);
        io_reset = 1'b0;
        step(1);
        check("midrst_ready_after", act_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1);
            check($sformatf("midrst_no_rsp_%0d", k), act_valid, 1'b0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            io_cmd_valid           = ($urandom_range(0, 9) < 7);
            io_cmd_payload_address = {32'($urandom_range(0, 3)), $urandom};
            io_cmd_payload_id      = 16'($urandom);
            io_stall               = ($urandom_range(0, 9) < 2);
            io_flush               = ($urandom_range(0, 39) == 0);
            io_load_valid          = ($urandom_range(0, 9) == 0);
            io_load_address        = {$urandom, $urandom};
            io_load_data           = {$urandom, $urandom};
            step(1);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
